fdtd_update_pipe: RTL and testbench
===================================

// Module: fdtd_update_pipe
// PURPOSE
// - Pipelined, multi-lane 1D FDTD field-update engine. Per beat it computes the Hy, Ez or source update
//   for LANES cells in parallel, using signed fixed point with rounding and saturation.
// - Sits between the field-memory read streamer and the write-back streamer in the fdtd plugin.
// - Adds valid/ready backpressure, a per-beat op select, saturation flagging and frame tracking.
// PARAMETERS
// - FDTD_DATA_WIDTH  32  signed field/coefficient width (DW)
// - FRAC_BITS        20  fraction bits of all operands; 1.0 = 1<<FRAC_BITS; range 1..DW-2
// - LANES            4   cells processed per beat
// - CNT_W            16  beat counter width
// PORTS
// - CLK           in   1         clock
// - RST_N         in   1         asynchronous active-low reset
// - in_valid_i    in   1         input beat valid
// - in_ready_o    out  1         input beat accepted when valid&ready
// - op_i          in   2         0=HY, 1=EZ, 2=SRC, 3=PASS; sampled with the beat
// - in_last_i     in   1         beat is last of frame
// - old_i         in   LANES*DW  previous field value per lane (lane n at [n*DW+:DW])
// - nbr_a_i       in   LANES*DW  HY: Ez[k+1]; EZ: Hy[k]; SRC: Jz
// - nbr_b_i       in   LANES*DW  HY: Ez[k]; EZ: Hy[k-1]; SRC: ignored
// - chyh,chyez,ceze,cezhy,cezj  in DW each  shared coefficients, sampled with the beat
// - out_valid_o   out  1         result beat valid
// - out_ready_i   in   1         downstream accepts
// - out_data_o    out  LANES*DW  updated field per lane
// - out_last_o    out  1         in_last_i carried through with the beat
// - sat_o         out  1         sticky: any lane saturated since reset/clr
// - clr_i         in   1         synchronous clear of sat_o and beat_cnt_o
// - beat_cnt_o    out  CNT_W     output handshakes in current frame
// - done_o        out  1         1-cycle pulse on handshake of the out_last beat
// BEHAVIOUR
// - Reset: all stage valids 0, out_valid_o 0, out_data_o 0, out_last_o 0, sat_o 0, beat_cnt_o 0, done_o 0.
//   Reset mid-stream discards all in-flight beats; no partial output.
// - Pipeline: 3 stages.
//   - S1 registers op, last, coefs, old, diff = nbr_a-nbr_b (DW+1 bits; SRC: diff = nbr_a sign-extended).
//   - S2 registers p0 and p1, each 2DW+2 signed:
//     HY p0=chyh*old,  p1=chyez*diff; EZ p0=ceze*old, p1=cezhy*diff;
//     SRC p0=old<<<FRAC_BITS, p1=cezj*diff.
//   - S3: s = p0+p1 (2DW+2 bits); r = (s + (1<<(FRAC_BITS-1))) >>> FRAC_BITS, i.e. round half up.
//     If r > 2^(DW-1)-1, output 0x7FF..F; if r < -2^(DW-1), output 0x800..0; either case sets sat_o.
//   - PASS: out = old bit-exact, never saturates.
// - Latency: exactly 3 cycles from input handshake to out_valid_o when out_ready_i is held 1.
//   Throughput is 1 beat/cycle.
// - Handshake: adv = !out_valid_o | out_ready_i; in_ready_o = adv; all stages shift only when adv=1.
//   - Bubbles move with the pipeline; no drops and no duplicates.
//   - out_data_o and out_last_o are stable while out_valid_o=1 and out_ready_i=0.
//   - in_ready_o depends on out_ready_i combinationally; that is the only comb path.
// - Frame tracking:
//   - beat_cnt_o increments on each output handshake and returns to 0 on the handshake of an
//     out_last beat; done_o pulses 1 on that cycle. It wraps at 2^CNT_W.
//   - clr_i zeroes beat_cnt_o and sat_o. If clr_i coincides with an increment or a new saturation,
//     clr_i wins and the counter reads 0 next cycle.
// - Saturation check applies to every lane independently; sat_o is the OR of all lanes, registered,
//   and is set in the cycle the saturated beat enters S3 output.
// - op_i is ignored when in_valid_i=0. Coefficient changes affect only subsequently accepted beats.
// TESTING (DW=32, FRAC=20, LANES=4; 1.0=0x00100000)
// - HY: chyh=1.0, chyez=0x00080000, old=0x00100000, a=0x00200000, b=0 all lanes, out_ready=1
//   -> out_data lanes=0x00200000 exactly 3 cycles after accept.
// - Saturation: EZ, ceze=1.0, cezhy=1.0, old=0x7FF00000, a=0x00200000, b=0 -> 0x7FFFFFFF, sat_o=1;
//   negative mirror -> 0x80000000. clr_i -> sat_o=0.
// - Rounding: EZ, ceze=0x00080000, cezhy=0, old=3 -> 2; old=0xFFFFFFFD -> 0xFFFFFFFF.
//   SRC: old=0x00100000, cezj=1.0, Jz=0x00100000 -> 0x00200000. PASS returns old.
// - Backpressure: 8-beat frame with out_ready low on cycles 3-7
//   -> all 8 beats out in order, no loss, data held stable while stalled.
//   beat_cnt 1..7 then 0; done_o one pulse with out_last.
// - Reset: assert RST_N=0 with 3 beats in flight -> out_valid_o=0 at once; after release, no stale
//   beats emerge and beat_cnt_o=0.

Source files
------------

// File: rtl/fdtd_update_pipe.sv
// Three-stage, multi-lane 1D FDTD field-update engine with valid/ready flow control,
// round-half-up fixed-point scaling, per-lane saturation and frame beat tracking.
`timescale 1ns/1ps

module fdtd_update_pipe #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int FRAC_BITS       = 20,
    parameter int LANES           = 4,
    parameter int CNT_W           = 16
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [1:0]                         op_i,
    input  logic                               in_last_i,
    input  logic [LANES*FDTD_DATA_WIDTH-1:0]   old_i,
    input  logic [LANES*FDTD_DATA_WIDTH-1:0]   nbr_a_i,
    input  logic [LANES*FDTD_DATA_WIDTH-1:0]   nbr_b_i,
    input  logic [FDTD_DATA_WIDTH-1:0]         chyh,
    input  logic [FDTD_DATA_WIDTH-1:0]         chyez,
    input  logic [FDTD_DATA_WIDTH-1:0]         ceze,
    input  logic [FDTD_DATA_WIDTH-1:0]         cezhy,
    input  logic [FDTD_DATA_WIDTH-1:0]         cezj,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [LANES*FDTD_DATA_WIDTH-1:0]   out_data_o,
    output logic                               out_last_o,
    output logic                               sat_o,
    input  logic                               clr_i,
    output logic [CNT_W-1:0]                   beat_cnt_o,
    output logic                               done_o
);

    localparam int DW = FDTD_DATA_WIDTH;
    localparam int PW = 2*DW + 2;

    localparam logic signed [PW-1:0] ONE   = 1;
    localparam logic signed [PW-1:0] RND   = ONE <<< (FRAC_BITS-1);
    localparam logic signed [PW-1:0] MAX_V = (ONE <<< (DW-1)) - ONE;
    localparam logic signed [PW-1:0] MIN_V = -(ONE <<< (DW-1));

    typedef enum logic [1:0] {
        OP_HY   = 2'd0,
        OP_EZ   = 2'd1,
        OP_SRC  = 2'd2,
        OP_PASS = 2'd3
    } op_e;

    // One global enable: every stage moves together, so bubbles travel with the data.
    logic adv;
    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    op_e op_in;
    assign op_in = op_e'(op_i);

    // Stage 1 state
    logic                 s1_valid, s1_last;
    op_e                  s1_op;
    logic signed [DW-1:0] s1_c0, s1_c1;
    logic signed [DW-1:0] s1_old  [LANES];
    logic signed [DW:0]   s1_diff [LANES];

    // Stage 2 state
    logic                 s2_valid, s2_last;
    logic signed [PW-1:0] s2_p0 [LANES];
    logic signed [PW-1:0] s2_p1 [LANES];

    // Stage 1 next-state: pick the coefficient pair for the op and form the neighbour difference.
    logic signed [DW-1:0] c0_d, c1_d;
    logic signed [DW:0]   diff_d [LANES];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        c0_d = '0;
        c1_d = '0;
        case (op_in)
            OP_HY:   begin c0_d = chyh; c1_d = chyez; end
            OP_EZ:   begin c0_d = ceze; c1_d = cezhy; end
            OP_SRC:  c1_d = cezj;
            default: ;
        endcase
        for (int n = 0; n < LANES; n++) begin
            if (op_in == OP_SRC)
                diff_d[n] = {nbr_a_i[n*DW+DW-1], nbr_a_i[n*DW +: DW]};
            else
                diff_d[n] = {nbr_a_i[n*DW+DW-1], nbr_a_i[n*DW +: DW]}
                          - {nbr_b_i[n*DW+DW-1], nbr_b_i[n*DW +: DW]};
        end
    end

    // Stage 2 next-state: SRC and PASS scale old to the product's binary point; PASS has c1 = 0.
    logic signed [PW-1:0] p0_d [LANES];
    logic signed [PW-1:0] p1_d [LANES];

    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            p1_d[n] = PW'(s1_c1) * PW'(s1_diff[n]);
            if (s1_op == OP_SRC || s1_op == OP_PASS)
                p0_d[n] = PW'(s1_old[n]) <<< FRAC_BITS;
            else
                p0_d[n] = PW'(s1_c0) * PW'(s1_old[n]);
        end
    end

    // Stage 3 next-state: sum, round half up, clamp each lane to the DW-bit signed range.
    logic signed [PW-1:0]  r_d [LANES];
    logic [LANES*DW-1:0]   data_d;
    logic                  sat_d;

    always_comb begin
        data_d = '0;
        sat_d  = 1'b0;
        for (int n = 0; n < LANES; n++) begin
            r_d[n] = (s2_p0[n] + s2_p1[n] + RND) >>> FRAC_BITS;
            if (r_d[n] > MAX_V) begin
                data_d[n*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
                sat_d              = 1'b1;
            end else if (r_d[n] < MIN_V) begin
                data_d[n*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
                sat_d              = 1'b1;
            end else begin
                data_d[n*DW +: DW] = r_d[n][DW-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_op       <= OP_HY;
            s1_c0       <= '0;
            s1_c1       <= '0;
            s2_valid    <= 1'b0;
            s2_last     <= 1'b0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            for (int n = 0; n < LANES; n++) begin
                s1_old[n]  <= '0;
                s1_diff[n] <= '0;
                s2_p0[n]   <= '0;
                s2_p1[n]   <= '0;
            end
        end else if (adv) begin
            s1_valid    <= in_valid_i;
            s1_last     <= in_last_i;
            s1_op       <= op_in;
            s1_c0       <= c0_d;
            s1_c1       <= c1_d;
            s2_valid    <= s1_valid;
            s2_last     <= s1_last;
            out_valid_o <= s2_valid;
            out_last_o  <= s2_last;
            out_data_o  <= data_d;
            for (int n = 0; n < LANES; n++) begin
                s1_old[n]  <= old_i[n*DW +: DW];
                s1_diff[n] <= diff_d[n];
                s2_p0[n]   <= p0_d[n];
                s2_p1[n]   <= p1_d[n];
            end
        end
    end

    // Frame tracking and sticky saturation; clr_i has priority over any same-cycle update.
    logic out_hs;
    assign out_hs = out_valid_o && out_ready_i;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sat_o      <= 1'b0;
            beat_cnt_o <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= out_hs && out_last_o;
            if (clr_i) begin
                sat_o      <= 1'b0;
                beat_cnt_o <= '0;
            end else begin
                if (adv && s2_valid && sat_d)
                    sat_o <= 1'b1;
                if (out_hs)
                    beat_cnt_o <= out_last_o ? '0 : beat_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fdtd_update_pipe.sv
// Scoreboard bench for fdtd_update_pipe: expected beats are queued at input handshake
// and compared at output handshake; frame counter and output stability are tracked per cycle.
`timescale 1ns/1ps

module tb_fdtd_update_pipe;

    localparam int DW = 32;
    localparam int L  = 4;
    localparam int W  = DW*L;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [1:0]    op_i = 2'd0;
    logic          in_last_i = 1'b0;
    logic [W-1:0]  old_i = '0, nbr_a_i = '0, nbr_b_i = '0;
    logic [DW-1:0] chyh = '0, chyez = '0, ceze = '0, cezhy = '0, cezj = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [W-1:0]  out_data_o;
    logic          out_last_o;
    logic          sat_o;
    logic          clr_i = 1'b0;
    logic [CW-1:0] beat_cnt_o;
    logic          done_o;

    fdtd_update_pipe #(
        .FDTD_DATA_WIDTH(DW), .FRAC_BITS(20), .LANES(L), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i), .in_last_i(in_last_i),
        .old_i(old_i), .nbr_a_i(nbr_a_i), .nbr_b_i(nbr_b_i),
        .chyh(chyh), .chyez(chyez), .ceze(ceze), .cezhy(cezhy), .cezj(cezj),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .sat_o(sat_o), .clr_i(clr_i),
        .beat_cnt_o(beat_cnt_o), .done_o(done_o)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [W:0] exp_q[$];
    logic exp_sat = 1'b0;
    logic tx_done = 1'b0;

    always @(posedge CLK) cyc++;

    // Per-cycle monitor: scoreboard pop, frame counter model, stall stability.
    logic [CW-1:0] m_cnt = '0;
    logic          m_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data;
    logic          prev_last;

    always @(negedge CLK) begin : monitor
        logic [W:0] item;
        logic hs, hs_last;
        if (!RST_N) begin
            m_cnt = '0; m_done = 1'b0; prev_stall = 1'b0;
        end else begin
            vectors++;
            if (beat_cnt_o !== m_cnt) begin
                miscompares++;
                $display("FAIL beat_cnt got %0d want %0d at cycle %0d", beat_cnt_o, m_cnt, cyc);
            end
            vectors++;
            if (done_o !== m_done) begin
                miscompares++;
                $display("FAIL done got %0b want %0b at cycle %0d", done_o, m_done, cyc);
            end
            if (prev_stall) begin
                vectors++;
                if (out_valid_o !== 1'b1 || out_data_o !== prev_data || out_last_o !== prev_last) begin
                    miscompares++;
                    $display("FAIL stall_hold got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                             out_valid_o, out_data_o, out_last_o, prev_data, prev_last);
                end
            end
            hs = out_valid_o && out_ready_i;
            hs_last = 1'b0;
            if (hs) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat got %h want none", out_data_o);
                end else begin
                    item = exp_q.pop_front();
                    hs_last = item[W];
                    if (out_data_o !== item[W-1:0] || out_last_o !== item[W]) begin
                        miscompares++;
                        $display("FAIL out_beat got %h last %0b want %h last %0b",
                                 out_data_o, out_last_o, item[W-1:0], item[W]);
                    end
                end
            end
            m_done = hs && hs_last;
            if (clr_i) m_cnt = '0;
            else if (hs) m_cnt = hs_last ? '0 : m_cnt + 16'd1;
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_last  = out_last_o;
        end
    end

    function automatic logic [W-1:0] rep(input logic [DW-1:0] v);
        return {L{v}};
    endfunction

    function automatic logic [DW-1:0] rnd_small();
        return $urandom_range(0, 32'h0040_0000) - 32'h0020_0000;
    endfunction

    // Reference arithmetic for one lane, carried out in wide signed integers.
    function automatic void model_lane(input logic [1:0] op, input logic [DW-1:0] old, a, b,
                                       output logic [DW-1:0] res, output logic sat);
        logic signed [127:0] o, av, bv, s, r;
        o = $signed(old); av = $signed(a); bv = $signed(b);
        s = 0; res = old; sat = 1'b0;
        case (op)
            2'd0:    s = $signed(chyh) * o + $signed(chyez) * (av - bv);
            2'd1:    s = $signed(ceze) * o + $signed(cezhy) * (av - bv);
            2'd2:    s = o * 128'sd1048576 + $signed(cezj) * av;
            default: s = 0;
        endcase
        if (op != 2'd3) begin
            r = (s + 128'sd524288) >>> 20;
            if (r > 128'sd2147483647) begin
                res = 32'h7FFF_FFFF; sat = 1'b1;
            end else if (r < -128'sd2147483648) begin
                res = 32'h8000_0000; sat = 1'b1;
            end else begin
                res = r[DW-1:0];
            end
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send_raw(input logic [1:0] op, input logic last,
                            input logic [W-1:0] old, a, b, input logic [W-1:0] exp);
        int waited;
        logic ok;
        op_i = op; in_last_i = last; old_i = old; nbr_a_i = a; nbr_b_i = b;
        in_valid_i = 1'b1;
        waited = 0; ok = 1'b0;
        while (!ok) begin
            @(negedge CLK);
            if (in_ready_o === 1'b1) ok = 1'b1;
            else if (++waited > 200) begin
                vectors++; miscompares++;
                $display("FAIL send_timeout got in_ready=%0b want 1", in_ready_o);
                @(posedge CLK); #1;
                in_valid_i = 1'b0;
                return;
            end
        end
        @(posedge CLK);
        exp_q.push_back({last, exp});
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic send_model(input logic [1:0] op, input logic last, input logic [W-1:0] old, a, b);
        logic [W-1:0] e;
        logic [DW-1:0] r;
        logic s;
        for (int n = 0; n < L; n++) begin
            model_lane(op, old[n*DW +: DW], a[n*DW +: DW], b[n*DW +: DW], r, s);
            e[n*DW +: DW] = r;
            exp_sat = exp_sat | s;
        end
        send_raw(op, last, old, a, b, e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid_o !== 1'b0) && t < 200) begin
            step(1); t++;
        end
        vectors++;
        if (exp_q.size() != 0 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1; step(1); clr_i = 1'b0;
        exp_sat = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        vectors++;
        if ({out_valid_o, out_last_o, sat_o, done_o} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags got v%0b l%0b s%0b d%0b want 0", out_valid_o, out_last_o, sat_o, done_o);
        end
        vectors++;
        if (out_data_o !== '0) begin
            miscompares++; $display("FAIL reset_data got %h want 0", out_data_o);
        end
        vectors++;
        if (beat_cnt_o !== '0) begin
            miscompares++; $display("FAIL reset_cnt got %0d want 0", beat_cnt_o);
        end
        @(posedge CLK); #1; RST_N = 1'b1;
        @(negedge CLK);
        vectors++;
        if (in_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready got %0b want 1", in_ready_o);
        end
        step(1);
    endtask

    task automatic test_hy_latency();
        chyh = 32'h0010_0000; chyez = 32'h0008_0000;
        send_raw(2'd0, 1'b0, rep(32'h0010_0000), rep(32'h0020_0000), rep(32'h0), rep(32'h0020_0000));
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            vectors++;
            if (out_valid_o !== (k == 3)) begin
                miscompares++;
                $display("FAIL latency got valid=%0b want %0b at +%0d", out_valid_o, (k == 3), k);
            end
        end
        step(1);
        drain();
    endtask

    task automatic test_saturation();
        ceze = 32'h0010_0000; cezhy = 32'h0010_0000;
        send_raw(2'd1, 1'b0, {32'h0, {3{32'h7FF0_0000}}}, rep(32'h0020_0000), rep(32'h0),
                 {32'h0020_0000, {3{32'h7FFF_FFFF}}});
        drain();
        vectors++;
        if (sat_o !== 1'b1) begin
            miscompares++; $display("FAIL sat_pos got %0b want 1", sat_o);
        end
        pulse_clr();
        @(negedge CLK);
        vectors++;
        if (sat_o !== 1'b0) begin
            miscompares++; $display("FAIL sat_clr got %0b want 0", sat_o);
        end
        step(1);
        send_raw(2'd1, 1'b0, {32'h0, {3{32'h8010_0000}}}, rep(32'hFFE0_0000), rep(32'h0),
                 {32'hFFE0_0000, {3{32'h8000_0000}}});
        drain();
        vectors++;
        if (sat_o !== 1'b1) begin
            miscompares++; $display("FAIL sat_neg got %0b want 1", sat_o);
        end
        pulse_clr();
    endtask

    task automatic test_rounding_ops();
        ceze = 32'h0008_0000; cezhy = 32'h0; cezj = 32'h0010_0000;
        chyh = 32'h7123_4567; chyez = 32'h8765_4321;
        send_raw(2'd1, 1'b0, {32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFD, 32'h3}, rep(32'h1234_5678), rep(32'h0),
                 {32'h0, 32'h1, 32'hFFFF_FFFF, 32'h2});
        send_raw(2'd2, 1'b0, rep(32'h0010_0000), rep(32'h0010_0000), rep(32'h7FFF_FFFF), rep(32'h0020_0000));
        send_raw(2'd3, 1'b0, {32'hDEAD_BEEF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1}, rep(32'h7FFF_FFFF),
                 rep(32'h8000_0000), {32'hDEAD_BEEF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1});
        drain();
        vectors++;
        if (sat_o !== 1'b0) begin
            miscompares++; $display("FAIL ops_nosat got %0b want 0", sat_o);
        end
    endtask

    task automatic test_clr_priority();
        int t;
        chyh = 32'h0010_0000; chyez = 32'h0;
        send_raw(2'd0, 1'b0, rep(32'h0000_1000), rep(32'h0), rep(32'h0), rep(32'h0000_1000));
        drain();
        out_ready_i = 1'b0;
        send_raw(2'd0, 1'b0, rep(32'h0000_2000), rep(32'h0), rep(32'h0), rep(32'h0000_2000));
        t = 0;
        while (out_valid_o !== 1'b1 && t < 20) begin step(1); t++; end
        out_ready_i = 1'b1; clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        @(negedge CLK);
        vectors++;
        if (beat_cnt_o !== '0) begin
            miscompares++; $display("FAIL clr_vs_inc got %0d want 0", beat_cnt_o);
        end
        step(1);
        drain();
        ceze = 32'h0010_0000; cezhy = 32'h0010_0000;
        send_raw(2'd1, 1'b0, {32'h0, {3{32'h7FF0_0000}}}, rep(32'h0020_0000), rep(32'h0),
                 {32'h0020_0000, {3{32'h7FFF_FFFF}}});
        step(1);
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        @(negedge CLK);
        vectors++;
        if (sat_o !== 1'b0 || out_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_vs_sat got sat=%0b valid=%0b want sat=0 valid=1", sat_o, out_valid_o);
        end
        step(1);
        drain();
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] cnts[$];
        int dones;
        logic prev_hs;
        pulse_clr();
        chyh = 32'h0010_0000; chyez = 32'h0004_0000;
        dones = 0; prev_hs = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_model(2'd0, i == 7, {32'(i*4+3) << 18, 32'(i*4+2) << 18, 32'(i*4+1) << 18, 32'(i*4) << 18},
                               rep(32'(i) << 20), rep(32'h0001_0000));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready_i = !(c >= 3 && c <= 7);
                    step(1);
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge CLK);
                    if (prev_hs) cnts.push_back(beat_cnt_o);
                    if (done_o === 1'b1) dones++;
                    prev_hs = out_valid_o && out_ready_i;
                end
            end
        join
        out_ready_i = 1'b1;
        drain();
        vectors++;
        if (cnts.size() != 8) begin
            miscompares++; $display("FAIL bp_handshakes got %0d want 8", cnts.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (cnts[i] !== ((i == 7) ? 16'd0 : 16'(i+1))) begin
                    miscompares++;
                    $display("FAIL bp_cnt[%0d] got %0d want %0d", i, cnts[i], (i == 7) ? 0 : i+1);
                end
            end
        end
        vectors++;
        if (dones != 1) begin
            miscompares++; $display("FAIL bp_done_pulses got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        out_ready_i = 1'b1;
        start = cyc;
        for (int i = 0; i < 20; i++) begin
            chyh = rnd_small(); chyez = rnd_small(); ceze = rnd_small(); cezhy = rnd_small();
            send_model(2'(i % 2), i == 19,
                       {rnd_small(), rnd_small(), rnd_small(), rnd_small()},
                       {rnd_small(), rnd_small(), rnd_small(), rnd_small()},
                       {rnd_small(), rnd_small(), rnd_small(), rnd_small()});
        end
        vectors++;
        if (cyc - start != 20) begin
            miscompares++; $display("FAIL throughput got %0d cycles want 20", cyc - start);
        end
        drain();
        @(negedge CLK);
        vectors++;
        if (beat_cnt_o !== '0) begin
            miscompares++; $display("FAIL b2b_cnt got %0d want 0", beat_cnt_o);
        end
        step(1);
    endtask

    task automatic test_random_stall();
        pulse_clr();
        tx_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [DW-1:0] big;
                    chyh = rnd_small(); chyez = rnd_small(); ceze = rnd_small();
                    cezhy = rnd_small(); cezj = rnd_small();
                    big = (i % 7 == 6) ? $urandom() : rnd_small();
                    send_model(2'($urandom_range(0, 3)), (i == 14) || (i == 29),
                               {big, rnd_small(), rnd_small(), rnd_small()},
                               {rnd_small(), big, rnd_small(), rnd_small()},
                               {rnd_small(), rnd_small(), rnd_small(), rnd_small()});
                end
                tx_done = 1'b1;
            end
            begin
                for (int c = 0; c < 600 && !(tx_done && exp_q.size() == 0); c++) begin
                    out_ready_i = 1'($urandom_range(0, 1));
                    step(1);
                end
                out_ready_i = 1'b1;
            end
        join
        drain();
        vectors++;
        if (sat_o !== exp_sat) begin
            miscompares++; $display("FAIL random_sat got %0b want %0b", sat_o, exp_sat);
        end
    endtask

    task automatic test_reset_midstream();
        chyh = 32'h0010_0000; chyez = 32'h0010_0000;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++)
            send_model(2'd0, 1'b0, rep(32'(i+1) << 20), rep(32'h0010_0000), rep(32'h0));
        RST_N = 1'b0;
        #1;
        vectors++;
        if (out_valid_o !== 1'b0 || beat_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL rst_mid got valid=%0b cnt=%0d want 0 0", out_valid_o, beat_cnt_o);
        end
        exp_q.delete();
        exp_sat = 1'b0;
        step(2);
        RST_N = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            vectors++;
            if (out_valid_o !== 1'b0) begin
                miscompares++; $display("FAIL rst_stale got valid=%0b want 0", out_valid_o);
            end
        end
        vectors++;
        if (beat_cnt_o !== '0) begin
            miscompares++; $display("FAIL rst_cnt got %0d want 0", beat_cnt_o);
        end
        step(1);
    endtask

    initial begin
        test_reset();
        test_hy_latency();
        test_saturation();
        test_rounding_ops();
        test_clr_priority();
        test_backpressure();
        test_back_to_back();
        test_random_stall();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
